// File: rtl/udma_lsu_pkg.sv
// udma_lsu_pkg: command bytes, frame lengths and FSM states shared by
// udma_lsu_host and udma_lsu_tap (checksum bytes under UDMA_LSU_HOST_CSUM_EN).
package udma_lsu_pkg;

  localparam logic [7:0] LSU_CMD_WR = 8'h57;
  localparam logic [7:0] LSU_CMD_RD = 8'h52;
  localparam logic [7:0] LSU_ACK    = 8'h4B;

`ifdef UDMA_LSU_HOST_CSUM_EN
  localparam int LSU_CSUM_BYTES = 1;
`else
  localparam int LSU_CSUM_BYTES = 0;
`endif

  localparam int LSU_WR_BYTES = 9 + LSU_CSUM_BYTES;
  localparam int LSU_RD_BYTES = 5 + LSU_CSUM_BYTES;
  localparam int LSU_WR_REPLY = 1 + LSU_CSUM_BYTES;
  localparam int LSU_RD_REPLY = 4 + LSU_CSUM_BYTES;
  localparam int LSU_FRAME_W  = 8 * LSU_WR_BYTES;

  // Reply bits kept: the checksum byte never lands in read data.
  localparam int LSU_RX_W = (LSU_CSUM_BYTES != 0) ? 32 : 24;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_SEND,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  function automatic logic [7:0] lsu_xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/udma_lsu_host.sv
// udma_lsu_host: serialises host load/store requests into UART command
// frames and parses replies. Optional checksums: UDMA_LSU_HOST_CSUM_EN.
module udma_lsu_host
  import udma_lsu_pkg::*;
#(
  parameter int              TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(1000000)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic        host_req_i,
  output logic        host_gnt_o,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_valid_o,
  output logic [31:0] host_rdata_o,
  output logic        host_err_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i
);

  localparam logic [3:0] WR_LAST = 4'(LSU_WR_BYTES - 1);
  localparam logic [3:0] RD_LAST = 4'(LSU_RD_BYTES - 1);
  localparam logic [2:0] WR_RLAST = 3'(LSU_WR_REPLY - 1);
  localparam logic [2:0] RD_RLAST = 3'(LSU_RD_REPLY - 1);
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

  lsu_state_e state_q, state_d;

  logic [LSU_FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]             bcnt_q;
  logic [2:0]             rcnt_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [LSU_RX_W-1:0]    rdata_q;
  logic                   we_q;
  logic                   sent_q;
  logic [31:0]            res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
`ifdef UDMA_LSU_HOST_CSUM_EN
  logic [7:0]             csum_q;
`endif

  logic take_req;
  logic tx_fire;
  logic last_byte;
  logic in_wait;
  logic rx_take;
  logic rx_done;
  logic to_hit;

  assign take_req  = (state_q == LSU_IDLE) && en_i && host_req_i;
  assign tx_fire   = (state_q == LSU_SEND) && en_i && !tx_busy_i && !sent_q;
  assign last_byte = bcnt_q == (we_q ? WR_LAST : RD_LAST);
  assign in_wait   = (state_q == LSU_WAIT) && en_i;
  assign rx_take   = in_wait && rx_valid_i;
  assign rx_done   = rx_take && (rcnt_q == (we_q ? WR_RLAST : RD_RLAST));
  assign to_hit    = to_cnt_q == TO_LAST;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= LSU_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE: if (take_req) state_d = LSU_SEND;
      LSU_SEND: if (tx_fire && last_byte) state_d = LSU_WAIT;
      LSU_WAIT: if (rx_done || to_hit) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
    if (!en_i) state_d = LSU_IDLE;
  end

  always_comb begin
    host_gnt_o   = take_req;
    host_valid_o = (state_q == LSU_DONE) && en_i;
    tx_valid_o   = tx_fire;
    tx_data_o    = tx_fire ? frame_q[LSU_FRAME_W-1 -: 8] : 8'h00;
    host_rdata_o = res_data_q;
    host_err_o   = res_err_q;
  end

  // Frames are left-aligned so every byte leaves from the top slice.
  always_comb begin
    frame_d = '0;
`ifdef UDMA_LSU_HOST_CSUM_EN
    if (host_we_i)
      frame_d = {LSU_CMD_WR, host_addr_i, host_wdata_i,
                 LSU_CMD_WR ^ lsu_xor4(host_addr_i) ^ lsu_xor4(host_wdata_i)};
    else
      frame_d[LSU_FRAME_W-1 -: 48] = {LSU_CMD_RD, host_addr_i,
                                      LSU_CMD_RD ^ lsu_xor4(host_addr_i)};
`else
    if (host_we_i)
      frame_d = {LSU_CMD_WR, host_addr_i, host_wdata_i};
    else
      frame_d[LSU_FRAME_W-1 -: 40] = {LSU_CMD_RD, host_addr_i};
`endif
  end

  always_comb begin
    logic       csum_ok;
    logic [7:0] ack;
    logic [31:0] rd;
    res_err_d  = 1'b1;
    res_data_d = 32'h0;
`ifdef UDMA_LSU_HOST_CSUM_EN
    csum_ok = (csum_q ^ rx_data_i) == 8'h00;
    ack     = rdata_q[7:0];
    rd      = rdata_q;
`else
    csum_ok = 1'b1;
    ack     = rx_data_i;
    rd      = {rdata_q, rx_data_i};
`endif
    if (rx_done) begin
      if (we_q) begin
        res_err_d = (ack != LSU_ACK) || !csum_ok;
      end else begin
        res_err_d  = !csum_ok;
        res_data_d = csum_ok ? rd : 32'h0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      frame_q    <= '0;
      bcnt_q     <= '0;
      rcnt_q     <= '0;
      to_cnt_q   <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      sent_q     <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
`ifdef UDMA_LSU_HOST_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      sent_q <= tx_fire;
      unique case (1'b1)
        take_req: begin
          we_q    <= host_we_i;
          frame_q <= frame_d;
          bcnt_q  <= '0;
        end
        tx_fire: begin
          frame_q <= frame_q << 8;
          bcnt_q  <= bcnt_q + 4'd1;
          if (last_byte) begin
            to_cnt_q <= '0;
            rcnt_q   <= '0;
            rdata_q  <= '0;
`ifdef UDMA_LSU_HOST_CSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        in_wait: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (rx_take) begin
            rcnt_q  <= rcnt_q + 3'd1;
            rdata_q <= {rdata_q[LSU_RX_W-9:0], rx_data_i};
`ifdef UDMA_LSU_HOST_CSUM_EN
            csum_q  <= csum_q ^ rx_data_i;
`endif
          end
          if (rx_done || to_hit) begin
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_lsu_host.sv
// tb_udma_lsu_host: directed bench for udma_lsu_host with a 50-cycle
// timeout; checksum cases are compiled in with UDMA_LSU_HOST_CSUM_EN.
module tb_udma_lsu_host;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        valid;
  logic [31:0] rdata;
  logic        err;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  int checks = 0;
  int errors = 0;

  udma_lsu_host #(.TO_W(24), .TIMEOUT_CYC(24'd50)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .en_i         (en),
    .host_req_i   (req),
    .host_gnt_o   (gnt),
    .host_we_i    (we),
    .host_addr_i  (addr),
    .host_wdata_i (wdata),
    .host_valid_o (valid),
    .host_rdata_o (rdata),
    .host_err_o   (err),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_busy_i    (tx_busy),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [7:0]  txq[$];
  logic [7:0]  exp_q[$];
  int          last_tx_cyc = 0;
  int          b2b = 0;
  logic        prev_txv = 1'b0;
  int          resp_cnt = 0;
  int          resp_cyc = 0;
  logic [31:0] resp_data = '0;
  logic        resp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_valid) begin
      txq.push_back(tx_data);
      last_tx_cyc = cyc;
      if (prev_txv) b2b++;
    end
    prev_txv = tx_valid;
    if (valid) begin
      resp_cnt++;
      resp_cyc  = cyc;
      resp_data = rdata;
      resp_err  = err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    int k = 0;
    logic got = 1'b0;
    txq.delete();
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    while (!got && k < 20) begin
      @(negedge clk);
      got = gnt;
      k++;
    end
    check("gnt", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic add_csum();
`ifdef UDMA_LSU_HOST_CSUM_EN
    logic [7:0] x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (txq.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (txq.size() < n) check("tx_wait", txq.size(), n);
  endtask

  task automatic frame_check(input string tag);
    wait_tx(exp_q.size());
    repeat (4) @(posedge clk);
    check({tag, "_len"}, txq.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < txq.size())
        check($sformatf("%s_b%0d", tag, i), txq[i], exp_q[i]);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_resp(input int n0, input string tag);
    int k = 0;
    while (resp_cnt == n0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_rsp"}, resp_cnt, n0 + 1);
  endtask

  initial begin
    int n0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {31'h0, gnt}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_txv", {31'h0, tx_valid}, 32'h0);
    check("rst_txd", {24'h0, tx_data}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // write
    n0 = resp_cnt;
    do_req(1'b1, 32'h1A2B3C4D, 32'hDEADBEEF);
    exp_q = '{8'h57, 8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_csum();
    frame_check("wr");
    rx_byte(8'h4B);
`ifdef UDMA_LSU_HOST_CSUM_EN
    rx_byte(8'h4B);
`endif
    wait_resp(n0, "wr");
    check("wr_err", {31'h0, resp_err}, 32'h0);
    check("wr_rdata", resp_data, 32'h0);

    // read
    n0 = resp_cnt;
    do_req(1'b0, 32'h00000010, 32'hFFFFFFFF);
    exp_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    add_csum();
    frame_check("rd");
    rx_byte(8'h12); rx_byte(8'h34); rx_byte(8'h56); rx_byte(8'h78);
`ifdef UDMA_LSU_HOST_CSUM_EN
    rx_byte(8'h08);
`endif
    wait_resp(n0, "rd");
    check("rd_err", {31'h0, resp_err}, 32'h0);
    check("rd_rdata", resp_data, 32'h12345678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rd_hold", rdata, 32'h12345678);

    // timeout: 50 cycles in WAIT_RESP between last byte and response
    n0 = resp_cnt;
    do_req(1'b0, 32'h00000020, 32'h0);
    exp_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    add_csum();
    wait_tx(exp_q.size());
    wait_resp(n0, "to");
    check("to_gap", resp_cyc - last_tx_cyc - 1, 50);
    check("to_err", {31'h0, resp_err}, 32'h1);
    check("to_rdata", resp_data, 32'h0);

    // bad ack, with stray rx bytes during SEND
    n0 = resp_cnt;
    do_req(1'b1, 32'h00000100, 32'h00000200);
    rx_byte(8'h4B); rx_byte(8'h4B);
    exp_q = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h00, 8'h00, 8'h02, 8'h00};
    add_csum();
    frame_check("bad");
    check("bad_stray", resp_cnt, n0);
    rx_byte(8'h4E);
`ifdef UDMA_LSU_HOST_CSUM_EN
    rx_byte(8'h4E);
`endif
    wait_resp(n0, "bad");
    check("bad_err", {31'h0, resp_err}, 32'h1);
    check("bad_rdata", resp_data, 32'h0);

    // tx_busy held mid-frame
    n0 = resp_cnt;
    b2b = 0;
    do_req(1'b1, 32'h01020304, 32'h05060708);
    wait_tx(3);
    @(posedge clk); #1;
    tx_busy = 1'b1;
    repeat (100) @(posedge clk);
    check("busy_hold", txq.size(), 3);
    #1 tx_busy = 1'b0;
    exp_q = '{8'h57, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08};
    add_csum();
    frame_check("busy");
    check("busy_b2b", b2b, 0);
    rx_byte(8'h4B);
`ifdef UDMA_LSU_HOST_CSUM_EN
    rx_byte(8'h4B);
`endif
    wait_resp(n0, "busy");
    check("busy_err", {31'h0, resp_err}, 32'h0);

    // enable dropped during WAIT_RESP
    n0 = resp_cnt;
    do_req(1'b0, 32'h00000030, 32'h0);
    wait_tx(5 + (exp_q.size() - 9));
    rx_byte(8'h12);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    repeat (80) @(posedge clk);
    check("en_abort", resp_cnt, n0);
    do_req(1'b1, 32'h00000040, 32'h11223344);
    exp_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h40,
              8'h11, 8'h22, 8'h33, 8'h44};
    add_csum();
    frame_check("en");
    rx_byte(8'h4B);
`ifdef UDMA_LSU_HOST_CSUM_EN
    rx_byte(8'h4B);
`endif
    wait_resp(n0, "en");
    check("en_err", {31'h0, resp_err}, 32'h0);

`ifdef UDMA_LSU_HOST_CSUM_EN
    n0 = resp_cnt;
    do_req(1'b1, 32'h00000001, 32'h00000002);
    wait_tx(10);
    repeat (4) @(posedge clk);
    check("cs_len", txq.size(), 10);
    check("cs_byte", txq[9], 8'h54);
    rx_byte(8'h4B); rx_byte(8'h4B);
    wait_resp(n0, "cs_ok");
    check("cs_ok_err", {31'h0, resp_err}, 32'h0);
    n0 = resp_cnt;
    do_req(1'b1, 32'h00000001, 32'h00000002);
    wait_tx(10);
    rx_byte(8'h4B); rx_byte(8'h00);
    wait_resp(n0, "cs_bad");
    check("cs_bad_err", {31'h0, resp_err}, 32'h1);
    check("cs_bad_rdata", resp_data, 32'h0);
`endif

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
